// File: rtl/signed_seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider and the Booth multiplier.
// Holds the FSM encoding, the counter-width rule and a conditional-negate helper.
package signed_seq_divider_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StAdj, StDone} state_e;

  // Helper datapath width; operand widths must stay below this.
  localparam int unsigned MathWidth = 32;

  // Iteration counter is wide enough to hold the operand width itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  localparam int unsigned DefCntWidth = cnt_width(16);

  // Two's-complement negate when neg is set; absolute value when neg is the sign bit.
  function automatic logic [MathWidth-1:0] cond_neg(input logic [MathWidth-1:0] v,
                                                    input logic neg);
    return neg ? (~v + MathWidth'(1)) : v;
  endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// Request/response bundle for the sequential divider (start_sig/done_sig handshake).
interface signed_seq_divider_if #(
  parameter int unsigned N_WIDTH = 16,
  parameter int unsigned D_WIDTH = 8
) ();

  logic               start_sig;
  logic [N_WIDTH-1:0] dividend;
  logic [D_WIDTH-1:0] divisor;
  logic               busy;
  logic               done_sig;
  logic [N_WIDTH-1:0] quotient;
  logic [D_WIDTH-1:0] remainder;
  logic               div_zero;
  logic               overflow;

  modport master (
    output start_sig, dividend, divisor,
    input  busy, done_sig, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start_sig, dividend, divisor,
    output busy, done_sig, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/signed_seq_divider_div_core_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it did not borrow.
module signed_seq_divider_div_core_step #(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic [D_WIDTH:0]   prem_i,
  input  logic               dvd_bit_i,
  input  logic [D_WIDTH-1:0] dvs_i,
  output logic [D_WIDTH:0]   prem_o,
  output logic               q_bit_o
);

  logic [D_WIDTH:0] shifted;
  logic [D_WIDTH:0] trial;
  logic             unused_prem_msb;

  // The partial remainder stays below the divisor, so its top bit is always zero.
  assign unused_prem_msb = prem_i[D_WIDTH];

  always_comb begin
    shifted = {prem_i[D_WIDTH-1:0], dvd_bit_i};
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[D_WIDTH];
    prem_o  = q_bit_o ? trial : shifted;
  end

endmodule

// File: rtl/signed_seq_divider.sv
// Signed 16/8 sequential divider: magnitudes divided one bit per cycle, signs and the
// divide-by-zero / overflow corner cases resolved in a single adjust cycle.
module signed_seq_divider
  import signed_seq_divider_pkg::*;
#(
  parameter int unsigned N_WIDTH = 16,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  signed_seq_divider_if.slave div_io
);

  localparam int unsigned CntW = cnt_width(N_WIDTH);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [N_WIDTH-1:0] dvd_q, dvd_d;
  logic [D_WIDTH-1:0] dvs_q, dvs_d;
  logic [D_WIDTH:0]   prem_q, prem_d;
  logic [D_WIDTH-1:0] dvd_lo_q, dvd_lo_d;
  logic               sign_n_q, sign_n_d;
  logic               sign_d_q, sign_d_d;
  logic               dz_q, dz_d;
  logic               ov_q, ov_d;

  logic [N_WIDTH-1:0] quotient_q, quotient_d;
  logic [D_WIDTH-1:0] remainder_q, remainder_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               overflow_q, overflow_d;

  logic [D_WIDTH:0]   step_prem;
  logic               step_q_bit;

  logic [MathWidth-1:0] dvd_abs_w, dvs_abs_w, quo_w, rem_w;
  logic                 unused_hi_bits;
  logic                 is_min_n, is_neg_one_d, is_zero_d;

  assign dvd_abs_w = cond_neg(MathWidth'(div_io.dividend), div_io.dividend[N_WIDTH-1]);
  assign dvs_abs_w = cond_neg(MathWidth'(div_io.divisor), div_io.divisor[D_WIDTH-1]);
  assign quo_w     = cond_neg(MathWidth'(dvd_q), sign_n_q ^ sign_d_q);
  assign rem_w     = cond_neg(MathWidth'(prem_q[D_WIDTH-1:0]), sign_n_q);

  assign unused_hi_bits = ^{dvd_abs_w[MathWidth-1:N_WIDTH], dvs_abs_w[MathWidth-1:D_WIDTH],
                            quo_w[MathWidth-1:N_WIDTH], rem_w[MathWidth-1:D_WIDTH]};

  assign is_min_n     = (div_io.dividend == {1'b1, {(N_WIDTH-1){1'b0}}});
  assign is_neg_one_d = &div_io.divisor;
  assign is_zero_d    = ~|div_io.divisor;

  signed_seq_divider_div_core_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .prem_i    (prem_q),
    .dvd_bit_i (dvd_q[N_WIDTH-1]),
    .dvs_i     (dvs_q),
    .prem_o    (step_prem),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    dvd_lo_d    = dvd_lo_q;
    sign_n_d    = sign_n_q;
    sign_d_d    = sign_d_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (div_io.start_sig) begin
          sign_n_d = div_io.dividend[N_WIDTH-1];
          sign_d_d = div_io.divisor[D_WIDTH-1];
          dvd_d    = dvd_abs_w[N_WIDTH-1:0];
          dvs_d    = dvs_abs_w[D_WIDTH-1:0];
          dvd_lo_d = div_io.dividend[D_WIDTH-1:0];
          dz_d     = is_zero_d;
          ov_d     = is_min_n & is_neg_one_d;
          prem_d   = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        // The dividend register doubles as the quotient shift register.
        dvd_d  = {dvd_q[N_WIDTH-2:0], step_q_bit};
        prem_d = step_prem;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N_WIDTH - 1)) begin
          state_d = StAdj;
        end
      end
      StAdj: begin
        done_d  = 1'b1;
        state_d = StDone;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_lo_q;
          div_zero_d  = 1'b1;
          overflow_d  = 1'b0;
        end else if (ov_q) begin
          quotient_d  = {1'b1, {(N_WIDTH-1){1'b0}}};
          remainder_d = '0;
          div_zero_d  = 1'b0;
          overflow_d  = 1'b1;
        end else begin
          quotient_d  = quo_w[N_WIDTH-1:0];
          remainder_d = rem_w[D_WIDTH-1:0];
          div_zero_d  = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      dvd_lo_q    <= '0;
      sign_n_q    <= 1'b0;
      sign_d_q    <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      dvd_lo_q    <= dvd_lo_d;
      sign_n_q    <= sign_n_d;
      sign_d_q    <= sign_d_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign div_io.busy      = (state_q != StIdle);
  assign div_io.done_sig  = done_q;
  assign div_io.quotient  = quotient_q;
  assign div_io.remainder = remainder_q;
  assign div_io.div_zero  = div_zero_q;
  assign div_io.overflow  = overflow_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider: the driver queues reference results at each
// accepted request, the monitor pops and compares on every done_sig pulse.
module tb_signed_seq_divider;

  localparam int unsigned NW = 16;
  localparam int unsigned DW = 8;
  localparam int          Latency = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  signed_seq_divider_if #(.N_WIDTH(NW), .D_WIDTH(DW)) bus ();

  signed_seq_divider #(
    .N_WIDTH (NW),
    .D_WIDTH (DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .div_io (bus)
  );

  typedef struct {
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ov;
    int            c0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic exp_t model(input logic [NW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   sa, sv;
    sa   = int'($signed(a));
    sv   = int'($signed(b));
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.c0 = 0;
    if (sv == 0) begin
      e.q  = '1;
      e.r  = a[DW-1:0];
      e.dz = 1'b1;
    end else if (sa == -(2 ** (NW - 1)) && sv == -1) begin
      e.q  = NW'(sa);
      e.r  = '0;
      e.ov = 1'b1;
    end else begin
      e.q = NW'(sa / sv);
      e.r = DW'(sa % sv);
    end
    return e;
  endfunction

  // Monitor: checks results on done_sig and that outputs hold steady in between.
  initial begin
    logic          prev_done;
    logic [NW-1:0] held_q;
    logic [DW-1:0] held_r;
    logic          held_dz, held_ov;
    exp_t          e;
    prev_done = 1'b0;
    held_q    = '0;
    held_r    = '0;
    held_dz   = 1'b0;
    held_ov   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_done = 1'b0;
        held_q    = '0;
        held_r    = '0;
        held_dz   = 1'b0;
        held_ov   = 1'b0;
      end else begin
        if (bus.done_sig) begin
          check("done_width", 32'(prev_done), 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(bus.done_sig), 32'd0);
          end else begin
            e = sb.pop_front();
            check("quotient", 32'(bus.quotient), 32'(e.q));
            check("remainder", 32'(bus.remainder), 32'(e.r));
            check("div_zero", 32'(bus.div_zero), 32'(e.dz));
            check("overflow", 32'(bus.overflow), 32'(e.ov));
            check("latency", 32'(cyc), 32'(e.c0 + Latency));
            held_q  = e.q;
            held_r  = e.r;
            held_dz = e.dz;
            held_ov = e.ov;
          end
        end else begin
          check("outputs_held", 32'({bus.quotient, bus.remainder, bus.div_zero, bus.overflow}),
                32'({held_q, held_r, held_dz, held_ov}));
        end
        prev_done = bus.done_sig;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic accept(input logic [NW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    e    = model(a, b);
    e.c0 = cyc;
    sb.push_back(e);
    check("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b);
    wait_idle();
    bus.start_sig = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    accept(a, b);
    bus.start_sig = 1'b0;
    bus.dividend  = NW'($urandom);
    bus.divisor   = DW'($urandom);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  int dir_a[7] = '{100, -100, 1000, 32767, -32768, 1234, -32768};
  int dir_b[7] = '{7, 7, -3, -128, 1, 0, -1};

  initial begin
    logic [NW-1:0] a, c;
    logic [DW-1:0] b, d;
    int            n;
    bus.start_sig = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done_sig), 32'd0);
    check("rst_results", 32'({bus.quotient, bus.remainder, bus.div_zero, bus.overflow}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_op(NW'(dir_a[i]), DW'(dir_b[i]));

    // start_sig held high: operands wiggle while busy, second accept on the 19th edge.
    wait_idle();
    a = NW'(5000);
    b = DW'(-9);
    c = NW'(-20000);
    d = DW'(77);
    bus.start_sig = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    accept(a, b);
    repeat (18) begin
      @(negedge clk);
      bus.dividend = NW'($urandom);
      bus.divisor  = DW'($urandom);
    end
    @(negedge clk);
    bus.dividend = c;
    bus.divisor  = d;
    accept(c, d);
    bus.start_sig = 1'b0;

    // Reset during CALC aborts the pending operation without a done pulse.
    run_op(NW'(100), DW'(7));
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done_sig), 32'd0);
    check("abort_results", 32'({bus.quotient, bus.remainder, bus.div_zero, bus.overflow}),
          32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    run_op(NW'(100), DW'(7));

    for (int i = 0; i < 150; i++) begin
      a = NW'($urandom);
      if ($urandom_range(0, 7) == 0) a = {1'b1, {(NW-1){1'b0}}};
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = '1;
        2:       b = {1'b1, {(DW-1){1'b0}}};
        default: b = DW'($urandom);
      endcase
      run_op(a, b);
    end

    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_seq_divider.md
Name: signed_seq_divider

Overview:
- Sequential two's-complement divider, the inverse datapath of the team's 8x8 Booth multiplier.
- Divides a 16-bit signed dividend by an 8-bit signed divisor, one quotient bit per clock (restoring algorithm on magnitudes).
- Produces a truncating-toward-zero quotient and a remainder that carries the dividend's sign.
- Uses the same start_sig/done_sig handshake as the multiplier, so both can sit side by side in the arithmetic unit.

Parameters:
- N_WIDTH, 16, dividend and quotient width in bits.
- D_WIDTH, 8, divisor and remainder width in bits; must be less than or equal to N_WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_sig  input  1  request; sampled only in IDLE.
- dividend  input  N_WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  D_WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high in every state other than IDLE.
- done_sig  output  1  one-cycle completion pulse.
- quotient  output  N_WIDTH  signed quotient; held until the next completion.
- remainder  output  D_WIDTH  signed remainder; held until the next completion.
- div_zero  output  1  divisor was 0; valid with done_sig, held until the next completion.
- overflow  output  1  dividend = most negative value and divisor = -1; valid and held like div_zero.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, done_sig, div_zero, overflow = 0; quotient = 0; remainder = 0; all internal registers cleared. Reset mid-operation aborts the operation with no done_sig pulse.
- States: IDLE -> CALC -> ADJ -> DONE -> IDLE.
- IDLE, start_sig=1 (edge E0):
  - latch the operand signs;
  - latch |dividend| as N_WIDTH unsigned and |divisor| as D_WIDTH unsigned;
  - compute the div_zero and overflow conditions into internal flags;
  - clear the partial remainder (D_WIDTH+1 bits) and the iteration counter;
  - go to CALC.
- CALC, edges E1..E_N (N_WIDTH cycles):
  - shift {partial remainder, dividend magnitude} left by 1;
  - trial-subtract |divisor|; if the result is non-negative, keep it and shift in quotient bit 1, else restore and shift in 0;
  - the counter increments; after the N_WIDTH-th iteration go to ADJ.
- ADJ (edge E_N+1):
  - register the outputs and set done_sig=1; go to DONE.
  - Normal case: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
  - div_zero: quotient = all ones; remainder = dividend[D_WIDTH-1:0]; div_zero=1; overflow=0.
  - overflow: quotient = 1 followed by zeros (most negative value); remainder = 0; overflow=1; div_zero=0.
  - div_zero and overflow are mutually exclusive (overflow requires divisor = -1).
- DONE (edge E_N+2): done_sig returns to 0; go to IDLE.
- Latency:
  - done_sig is high exactly during the cycle after edge E17, i.e. 17 cycles after the accepting edge for the defaults.
  - busy rises after E0 and falls after E18.
  - Latency is fixed, including the div_zero and overflow cases, which run the full CALC sequence.
- Handshake:
  - start_sig is ignored while busy=1; operands need only be valid on the accepting edge.
  - If start_sig is held high, a new operation is accepted on the first edge in IDLE (E19), giving back-to-back operation every 19 cycles.
- Width rules:
  - Magnitudes are unsigned, so |most-negative dividend| = 2^(N_WIDTH-1) is representable.
  - |remainder| < |divisor| <= 2^(D_WIDTH-1), so the signed remainder always fits D_WIDTH.
  - The trial subtraction uses D_WIDTH+1 bits to preserve the borrow.

Decomposition:
- Shared arithmetic package: state encoding (IDLE/CALC/ADJ/DONE), a counter-width constant = clog2(N_WIDTH)+1, and an absolute-value/negate helper function.
- The multiplier is also to be migrated onto this package.
- One sub-module is natural: div_core_step, a combinational single restoring iteration (partial remainder and dividend bits in; next partial remainder and quotient bit out).
- The FSM, sign handling and output registers stay in the top.

Test Plan:
- 100 / 7 -> quotient=16'h000E, remainder=8'h02, flags 0; done_sig high for exactly 1 cycle, 17 cycles after acceptance.
- -100 / 7 -> quotient=16'hFFF2 (-14), remainder=8'hFE (-2); 1000 / -3 -> quotient=16'hFEB3 (-333), remainder=8'h01.
- 32767 / -128 -> quotient=16'hFF01 (-255), remainder=8'h7F; -32768 / 1 -> quotient=16'h8000, remainder=0, overflow=0.
- 1234 / 0 -> div_zero=1, quotient=16'hFFFF, remainder=8'hD2. Then -32768 / -1 -> overflow=1, div_zero=0, quotient=16'h8000, remainder=0.
- start_sig held high with operands changed during busy -> changed operands ignored; second operation accepted on the 19th edge; outputs from the first operation held until the second done_sig.
- Assert rst at cycle 8 of CALC -> all outputs 0 immediately, no done_sig; after release, a new 100 / 7 completes correctly.
